uba_intr_arb: RTL and testbench
===============================

// Module: uba_intr_arb
// PURPOSE
//  Interrupt arbiter/sequencer for one IO Bridge (UBA). It shares the UBA's two PI channels (high and low) among NDEV Unibus devices.
//  It drives the backplane interrupt request and serves CPU interrupt-vector read cycles: it picks the winning device, pulses its acknowledge and returns its vector.
//  It sits beside the UBA status/maintenance registers, which supply the PIH/PIL level fields.
// PARAMETERS
//  NDEV    4          number of devices; index 0 = highest priority
//  HIMASK  4'b0011    bit i set: device i is on the high (BR7/BR6) group, clear: low (BR5/BR4) group
//  TOCNT   255        cycles to wait in WAITCLR for the request to drop (8-bit counter)
// PORTS
//  clk         in   1       clock
//  rst         in   1       reset, asynchronous, active-low
//  regPIH      in   3       PI level for the high group; 0 = disabled
//  regPIL      in   3       PI level for the low group; 0 = disabled
//  devINTR     in   NDEV    per-device interrupt request, level
//  devVECT     in   NDEV*16 per-device vector; device i owns [16i+15:16i]
//  vectRD      in   1       CPU vector read, level, held until vectVALID
//  vectPI      in   3       PI level being acknowledged; sampled with vectRD
//  busINTR     out  7       PI request; bit k-1 = level k
//  vectVALID   out  1       vector valid
//  vectDATA    out  36      vector, zero-extended to 36 bits
//  vectNODEV   out  1       no requester at vectPI; vectDATA = 0
//  devIACK     out  NDEV    one-hot acknowledge, one-cycle pulse
//  arbTIMEOUT  out  1       one-cycle pulse when the WAITCLR timeout expires
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, timeout counter 0. Reset asserted in any state returns to IDLE immediately (async).
//  busINTR (combinational from registered devINTR)
//   - Level regPIH is requested if any enabled high-group device requests.
//   - Level regPIL is requested likewise for the low group.
//   - A group at level 0 contributes nothing. If PIH == PIL, the two requests OR onto that bit.
//  FSM: IDLE -> ARB -> ACK -> WAITCLR -> IDLE
//   - IDLE: vectRD=1 -> latch vectPI, go to ARB.
//   - ARB: form the candidate set: devINTR & group mask, for each group whose level == latched PI.
//     - Winner = lowest index in that set; the high group beats the low group when both levels match.
//     - The devINTR snapshot is taken in this cycle only; later request changes do not alter the winner.
//   - ACK (one cycle): if a winner exists, devIACK[w]=1, vectDATA={20'b0, devVECT[w]}, vectVALID=1.
//     - If no winner: vectNODEV=1, vectDATA=0, vectVALID=1, devIACK=0.
//   - WAITCLR: hold vectVALID/vectDATA/vectNODEV until vectRD=0.
//     - Also wait for devINTR[w]=0, or timeout after TOCNT cycles (arbTIMEOUT pulse).
//     - Return to IDLE only when both conditions are satisfied. Clear vectVALID on exit.
//  Latency: vectRD rises in cycle N; vectVALID and devIACK appear in cycle N+2.
//  vectRD dropped before ACK: the cycle still completes the ACK pulse; data is discarded.
//  vectRD re-asserted in the IDLE exit cycle: serviced from the next cycle only (no back-to-back in WAITCLR).
//  vectPI = 0 or unmatched: NODEV path.
//  Timeout counter: saturating, 8 bits; cleared on WAITCLR entry.
// STRUCTURE
//  Shared package uba_pkg: typedef enum {IDLE,ARB,ACK,WAITCLR} arb_state_t; constants UBA_VECW=16, UBA_PIW=3.
//  One sub-module: uba_prio_enc. A parameterised lowest-index priority encoder returning a one-hot result and a valid flag; instantiated once per group.
// TESTING
//  1. Reset: rst=0 mid-WAITCLR -> all outputs 0, state IDLE next cycle.
//  2. PIH=5, dev1 requests -> busINTR[4]=1. vectRD, vectPI=5 -> cycle N+2: devIACK=4'b0010, vectDATA=dev1 vector (e.g. 'o000254).
//  3. PIH=PIL=3, dev0 (high) and dev2 (low) both request, vectPI=3 -> dev0 wins. After dev0 clears, a second read -> dev2.
//  4. vectPI=6 with no group at 6 -> vectVALID=1, vectNODEV=1, vectDATA=0, devIACK=0.
//  5. Winner holds devINTR high -> arbTIMEOUT pulse after 255 WAITCLR cycles; then IDLE once vectRD=0.
//  6. PIL=0, low-group device requests -> busINTR=0. A vector read at any level -> NODEV.

Source files
------------

// File: rtl/uba_pkg.sv
// ----------------------------------------------------------------------------
// uba_pkg
//   Shared types and constants for the UBA interrupt arbiter slice.
//   - arb_state_t : vector-read sequencer states
//   - UBA_VECW    : width of one device interrupt vector
//   - UBA_PIW     : width of a PI level field
//   - UBA_DATAW   : width of the CPU-side vector data bus
// ----------------------------------------------------------------------------
package uba_pkg;

    localparam int UBA_VECW  = 16;
    localparam int UBA_PIW   = 3;
    localparam int UBA_DATAW = 36;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARB     = 2'd1,
        ACK     = 2'd2,
        WAITCLR = 2'd3
    } arb_state_t;

    // A PI field of zero means the group is switched off.
    function automatic logic pi_enabled(input logic [UBA_PIW-1:0] lvl);
        return (lvl != '0);
    endfunction

endpackage

// File: rtl/uba_prio_enc.sv
// ----------------------------------------------------------------------------
// uba_prio_enc
//   Lowest-index-wins priority encoder.
//   Ports:
//     req    in  N   request vector, bit 0 = highest priority
//     onehot out N   one-hot grant of the lowest set request bit (0 if none)
//     valid  out 1   at least one request present
// ----------------------------------------------------------------------------
module uba_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] onehot,
    output logic         valid
);

    // Two's-complement trick: req & -req isolates the lowest set bit.
    assign onehot = req & (~req + N'(1));
    assign valid  = |req;

endmodule

// File: rtl/uba_intr_arb.sv
// ----------------------------------------------------------------------------
// uba_intr_arb
//   Interrupt arbiter/sequencer for one UBA. Shares the high and low PI
//   channels among NDEV Unibus devices, drives the backplane PI request and
//   answers CPU vector-read cycles with the winning device's vector.
//   Ports:
//     clk        in   1         clock
//     rst        in   1         asynchronous active-low reset
//     regPIH     in   3         PI level of the high group (0 = off)
//     regPIL     in   3         PI level of the low group (0 = off)
//     devINTR    in   NDEV      per-device level interrupt request
//     devVECT    in   NDEV*16   per-device vector, device i at [16i+15:16i]
//     vectRD     in   1         CPU vector read, held until vectVALID
//     vectPI     in   3         PI level being acknowledged
//     busINTR    out  7         PI request, bit k-1 = level k
//     vectVALID  out  1         vector valid
//     vectDATA   out  36        zero-extended vector
//     vectNODEV  out  1         no requester at the acknowledged level
//     devIACK    out  NDEV      one-hot, one-cycle acknowledge
//     arbTIMEOUT out  1         one-cycle pulse when the clear wait expires
// ----------------------------------------------------------------------------
module uba_intr_arb
    import uba_pkg::*;
#(
    parameter int              NDEV   = 4,
    parameter logic [NDEV-1:0] HIMASK = 4'b0011,
    parameter int              TOCNT  = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [UBA_PIW-1:0]       regPIH,
    input  logic [UBA_PIW-1:0]       regPIL,
    input  logic [NDEV-1:0]          devINTR,
    input  logic [NDEV*UBA_VECW-1:0] devVECT,
    input  logic                     vectRD,
    input  logic [UBA_PIW-1:0]       vectPI,
    output logic [6:0]               busINTR,
    output logic                     vectVALID,
    output logic [UBA_DATAW-1:0]     vectDATA,
    output logic                     vectNODEV,
    output logic [NDEV-1:0]          devIACK,
    output logic                     arbTIMEOUT
);

    localparam logic [7:0] TO_LIM   = 8'(TOCNT);
    localparam logic [7:0] TO_LIMM1 = 8'(TOCNT - 1);

    arb_state_t             state_q, state_d;
    logic [UBA_PIW-1:0]     pi_q, pi_d;
    logic [NDEV-1:0]        devintr_q, devintr_d;
    logic [NDEV-1:0]        win_q, win_d;
    logic                   valid_q, valid_d;
    logic                   nodev_q, nodev_d;
    logic [UBA_DATAW-1:0]   data_q, data_d;
    logic [NDEV-1:0]        iack_q, iack_d;
    logic                   tmo_q, tmo_d;
    logic [7:0]             cnt_q, cnt_d;

    // ------------------------------------------------------------------
    // Backplane request, from the registered copy of devINTR
    // ------------------------------------------------------------------
    logic hi_req;
    logic lo_req;

    assign devintr_d = devINTR;
    assign hi_req    = |(devintr_q & HIMASK);
    assign lo_req    = |(devintr_q & ~HIMASK);

    // A level-0 group never matches gi+1, so a disabled group drops out
    // naturally; equal levels OR onto the same bit.
    for (genvar gi = 0; gi < 7; gi++) begin : g_bus
        assign busINTR[gi] = (hi_req && (regPIH == UBA_PIW'(gi + 1)))
                          || (lo_req && (regPIL == UBA_PIW'(gi + 1)));
    end

    // ------------------------------------------------------------------
    // Arbitration: candidate sets per group at the latched PI level
    // ------------------------------------------------------------------
    logic            hi_match, lo_match;
    logic [NDEV-1:0] hi_cand, lo_cand;
    logic [NDEV-1:0] hi_oh, lo_oh;
    logic            hi_vld, lo_vld;
    logic [NDEV-1:0] win_sel;
    logic            win_any;
    logic [UBA_VECW-1:0] win_vec;

    assign hi_match = pi_enabled(pi_q) && (pi_q == regPIH);
    assign lo_match = pi_enabled(pi_q) && (pi_q == regPIL);
    assign hi_cand  = hi_match ? (devINTR & HIMASK)  : '0;
    assign lo_cand  = lo_match ? (devINTR & ~HIMASK) : '0;

    uba_prio_enc #(.N(NDEV)) u_enc_hi (
        .req    (hi_cand),
        .onehot (hi_oh),
        .valid  (hi_vld)
    );

    uba_prio_enc #(.N(NDEV)) u_enc_lo (
        .req    (lo_cand),
        .onehot (lo_oh),
        .valid  (lo_vld)
    );

    // High group takes precedence when both groups sit at the acked level.
    assign win_sel = hi_vld ? hi_oh : lo_oh;
    assign win_any = hi_vld | lo_vld;

    // One-hot AND-OR vector mux.
    logic [UBA_VECW-1:0] vec_masked [NDEV];
    for (genvar gi = 0; gi < NDEV; gi++) begin : g_vmux
        assign vec_masked[gi] = win_sel[gi] ? devVECT[gi*UBA_VECW +: UBA_VECW]
                                            : '0;
    end

    always_comb begin
        win_vec = '0;
        for (int i = 0; i < NDEV; i++) begin
            win_vec = win_vec | vec_masked[i];
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    logic intr_clr;
    logic tmo_done;

    // With no winner win_q is zero, so the device condition is already met.
    assign intr_clr = ~|(win_q & devINTR);
    assign tmo_done = (cnt_q == TO_LIM);

    always_comb begin
        state_d = state_q;
        pi_d    = pi_q;
        win_d   = win_q;
        valid_d = valid_q;
        nodev_d = nodev_q;
        data_d  = data_q;
        iack_d  = '0;
        tmo_d   = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (vectRD) begin
                    pi_d    = vectPI;
                    state_d = ARB;
                end
            end

            ARB: begin
                // Winner is frozen here; later devINTR changes are ignored.
                win_d   = win_sel;
                iack_d  = win_sel;
                valid_d = 1'b1;
                nodev_d = ~win_any;
                data_d  = {{(UBA_DATAW-UBA_VECW){1'b0}}, win_vec};
                state_d = ACK;
            end

            ACK: begin
                cnt_d   = '0;
                state_d = WAITCLR;
            end

            WAITCLR: begin
                if (!intr_clr && !tmo_done) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == TO_LIMM1) begin
                        tmo_d = 1'b1;
                    end
                end
                if (!vectRD && (intr_clr || tmo_done)) begin
                    valid_d = 1'b0;
                    nodev_d = 1'b0;
                    data_d  = '0;
                    win_d   = '0;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pi_q      <= '0;
            devintr_q <= '0;
            win_q     <= '0;
            valid_q   <= 1'b0;
            nodev_q   <= 1'b0;
            data_q    <= '0;
            iack_q    <= '0;
            tmo_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pi_q      <= pi_d;
            devintr_q <= devintr_d;
            win_q     <= win_d;
            valid_q   <= valid_d;
            nodev_q   <= nodev_d;
            data_q    <= data_d;
            iack_q    <= iack_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
        end
    end

    assign vectVALID  = valid_q;
    assign vectNODEV  = nodev_q;
    assign vectDATA   = data_q;
    assign devIACK    = iack_q;
    assign arbTIMEOUT = tmo_q;

endmodule

// File: tb/tb_uba_intr_arb.sv
// ----------------------------------------------------------------------------
// tb_uba_intr_arb
//   Directed-vector bench for uba_intr_arb with hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_uba_intr_arb;

    logic        clk;
    logic        rst;
    logic [2:0]  regPIH;
    logic [2:0]  regPIL;
    logic [3:0]  devINTR;
    logic [63:0] devVECT;
    logic        vectRD;
    logic [2:0]  vectPI;
    logic [6:0]  busINTR;
    logic        vectVALID;
    logic [35:0] vectDATA;
    logic        vectNODEV;
    logic [3:0]  devIACK;
    logic        arbTIMEOUT;

    int checks = 0;
    int errors = 0;

    uba_intr_arb #(
        .NDEV   (4),
        .HIMASK (4'b0011),
        .TOCNT  (255)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .regPIH     (regPIH),
        .regPIL     (regPIL),
        .devINTR    (devINTR),
        .devVECT    (devVECT),
        .vectRD     (vectRD),
        .vectPI     (vectPI),
        .busINTR    (busINTR),
        .vectVALID  (vectVALID),
        .vectDATA   (vectDATA),
        .vectNODEV  (vectNODEV),
        .devIACK    (devIACK),
        .arbTIMEOUT (arbTIMEOUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a vector read and check the fixed two-cycle latency and the ACK
    // cycle contents. Returns in the first WAITCLR cycle with vectRD held.
    task automatic do_read(input string tag, input logic [2:0] pi,
                           input logic [3:0] e_iack, input logic [15:0] e_vec,
                           input logic e_nodev);
        vectRD = 1'b1;
        vectPI = pi;
        tick();
        chk({tag, "_n1_valid"}, vectVALID, 1'b0);
        tick();
        chk({tag, "_valid"}, vectVALID, 1'b1);
        chk({tag, "_iack"},  devIACK,   e_iack);
        chk({tag, "_data"},  vectDATA,  {20'b0, e_vec});
        chk({tag, "_nodev"}, vectNODEV, e_nodev);
        $display("read %s pi=%0d iack=%b data=%o nodev=%b", tag, pi, devIACK, vectDATA, vectNODEV);
        tick();
        chk({tag, "_iack_pulse"}, devIACK, 4'b0000);
    endtask

    task automatic wait_idle(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (!vectVALID) break;
            tick();
        end
        chk({tag, "_idle"}, vectVALID, 1'b0);
    endtask

    initial begin
        int n;
        rst     = 1'b0;
        regPIH  = 3'd0;
        regPIL  = 3'd0;
        devINTR = 4'b0000;
        devVECT = {16'o000264, 16'o000260, 16'o000254, 16'o000250};
        vectRD  = 1'b0;
        vectPI  = 3'd0;
        tick();
        tick();
        chk("rst_valid", vectVALID, 1'b0);
        chk("rst_data",  vectDATA,  36'd0);
        chk("rst_iack",  devIACK,   4'b0000);
        chk("rst_bus",   busINTR,   7'd0);
        chk("rst_tmo",   arbTIMEOUT, 1'b0);
        rst = 1'b1;
        tick();

        // PIH=5, dev1 requests
        regPIH  = 3'd5;
        regPIL  = 3'd2;
        devINTR = 4'b0010;
        tick();
        chk("t2_bus", busINTR, 7'b0010000);
        do_read("t2", 3'd5, 4'b0010, 16'o000254, 1'b0);
        vectRD = 1'b0;
        tick();
        tick();
        chk("t2_hold_valid", vectVALID, 1'b1);
        chk("t2_hold_data", vectDATA, {20'b0, 16'o000254});
        devINTR = 4'b0000;
        wait_idle("t2", 10);

        // Equal levels: high group dev0 beats low group dev2
        regPIH  = 3'd3;
        regPIL  = 3'd3;
        devINTR = 4'b0101;
        tick();
        chk("t3_bus", busINTR, 7'b0000100);
        do_read("t3a", 3'd3, 4'b0001, 16'o000250, 1'b0);
        devINTR = 4'b0100;
        vectRD  = 1'b0;
        wait_idle("t3a", 10);
        do_read("t3b", 3'd3, 4'b0100, 16'o000260, 1'b0);
        devINTR = 4'b0000;
        vectRD  = 1'b0;
        wait_idle("t3b", 10);

        // Unmatched level -> NODEV
        devINTR = 4'b0001;
        do_read("t4", 3'd6, 4'b0000, 16'd0, 1'b1);
        vectRD = 1'b0;
        wait_idle("t4", 10);
        devINTR = 4'b0000;
        tick();

        // Async reset while parked in WAITCLR
        regPIH  = 3'd5;
        devINTR = 4'b0010;
        tick();
        do_read("t1", 3'd5, 4'b0010, 16'o000254, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("t1_valid", vectVALID, 1'b0);
        chk("t1_data",  vectDATA,  36'd0);
        chk("t1_nodev", vectNODEV, 1'b0);
        chk("t1_bus",   busINTR,   7'd0);
        vectRD  = 1'b0;
        devINTR = 4'b0000;
        tick();
        rst = 1'b1;
        tick();
        devINTR = 4'b0010;
        do_read("t1b", 3'd5, 4'b0010, 16'o000254, 1'b0);

        // Winner never clears -> timeout pulse, then exit with vectRD low
        vectRD = 1'b0;
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (arbTIMEOUT) begin
                n = i;
                break;
            end
        end
        chk("t5_tmo_cycles", n, 255);
        chk("t5_valid_at_tmo", vectVALID, 1'b1);
        tick();
        chk("t5_tmo_pulse", arbTIMEOUT, 1'b0);
        chk("t5_exit", vectVALID, 1'b0);
        devINTR = 4'b0000;
        tick();

        // Low group disabled
        regPIH  = 3'd5;
        regPIL  = 3'd0;
        devINTR = 4'b1000;
        tick();
        chk("t6_bus", busINTR, 7'd0);
        do_read("t6a", 3'd0, 4'b0000, 16'd0, 1'b1);
        vectRD = 1'b0;
        wait_idle("t6a", 10);
        do_read("t6b", 3'd5, 4'b0000, 16'd0, 1'b1);
        vectRD = 1'b0;
        wait_idle("t6b", 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
